alu_issue_stage: RTL and testbench

- Pipelined issue/retire stage wrapped around the 32-bit combinational ALU.
- Execute side: decodes the main-control ALUop plus funct/opcode into the 3-bit ALU operation code, selects and registers the operands, and drives the ALU.
- Retire side: captures the ALU's res/zero/overflow into a writeback register.
- Sits between ID and WB of the CPU datapath; valid/ready handshake on both sides.

---
 rtl/alu_issue_stage.sv | 116 +++++++++++
 tb/tb_alu_issue_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALU control and registers operands (E), then captures ALU results for writeback (W).
// Valid/ready on both sides; flush kills only the E entry.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [5:0]  opcode,
    input  logic [4:0]  shamt,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    output logic [2:0]  alu_operation,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_zero,
    output logic        out_ovf_trap,
    output logic        out_illegal
);
    logic        e_valid, e_signed, e_illegal;
    logic        w_free, e_advance, accept;
    logic [2:0]  d_op;
    logic [31:0] d_a, d_b, sext, zext;
    logic        d_signed, d_illegal;

    assign sext      = {{16{imm[15]}}, imm};
    assign zext      = {16'h0, imm};
    assign w_free    = !out_valid || out_ready;
    assign e_advance = e_valid && w_free;
    assign in_ready  = !flush && (!e_valid || w_free);
    assign accept    = in_valid && in_ready;

    always_comb begin
        d_op      = 3'b100;
        d_a       = rs_data;
        d_b       = rt_data;
        d_signed  = 1'b0;
        d_illegal = 1'b0;
        case (alu_op)
            2'b00: begin
                d_op = 3'b000;
                d_b  = sext;
            end
            2'b01: d_op = 3'b001;
            2'b10: case (funct)
                6'b100000: begin d_op = 3'b000; d_signed = 1'b1; end
                6'b100001: d_op = 3'b000;
                6'b100010: begin d_op = 3'b001; d_signed = 1'b1; end
                6'b100011: d_op = 3'b001;
                6'b100100: d_op = 3'b010;
                6'b100101: d_op = 3'b011;
                6'b101010: d_op = 3'b111;
                6'b000010: begin
                    d_op = 3'b101;
                    d_a  = rt_data;
                    d_b  = {27'b0, shamt};
                end
                default:   d_illegal = 1'b1;
            endcase
            2'b11: case (opcode)
                6'b001000: begin d_op = 3'b000; d_b = sext; d_signed = 1'b1; end
                6'b001100: begin d_op = 3'b010; d_b = zext; end
                6'b001101: begin d_op = 3'b011; d_b = zext; end
                6'b001010: begin d_op = 3'b111; d_b = sext; end
                6'b001111: begin d_op = 3'b110; d_b = zext; end
                default:   d_illegal = 1'b1;
            endcase
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid       <= 1'b0;
            e_signed      <= 1'b0;
            e_illegal     <= 1'b0;
            alu_operation <= 3'b0;
            alu_a         <= 32'b0;
            alu_b         <= 32'b0;
            out_valid     <= 1'b0;
            out_res       <= 32'b0;
            out_zero      <= 1'b0;
            out_ovf_trap  <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            if (flush)
                e_valid <= 1'b0;
            else if (accept) begin
                e_valid       <= 1'b1;
                alu_operation <= d_op;
                alu_a         <= d_a;
                alu_b         <= d_b;
                e_signed      <= d_signed;
                e_illegal     <= d_illegal;
            end else if (e_advance)
                e_valid <= 1'b0;
            // The entry leaving E on a flush edge still lands in W.
            if (e_advance) begin
                out_valid    <= 1'b1;
                out_res      <= alu_res;
                out_zero     <= alu_zero;
                out_ovf_trap <= alu_overflow && e_signed && !e_illegal;
                out_illegal  <= e_illegal;
            end else if (out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table vectors, stall/flush/reset sequences and a random stream checked against a queue-based model.
module tb_alu_issue_stage;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, in_ready, out_ready = 0;
    logic [1:0]  alu_op = 0;
    logic [5:0]  funct = 0, opcode = 0;
    logic [4:0]  shamt = 0;
    logic [31:0] rs_data = 0, rt_data = 0;
    logic [15:0] imm = 0;
    logic [2:0]  alu_operation;
    logic [31:0] alu_a, alu_b, alu_res, out_res, diff;
    logic        alu_zero, alu_overflow, out_valid, out_zero, out_ovf_trap, out_illegal;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .opcode(opcode), .shamt(shamt),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_zero(out_zero), .out_ovf_trap(out_ovf_trap), .out_illegal(out_illegal)
    );

    // Stand-in for the combinational ALU the stage drives.
    always_comb begin
        diff         = alu_a - alu_b;
        alu_res      = 32'h0;
        alu_overflow = 1'b0;
        case (alu_operation)
            3'd0: begin
                alu_res      = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
            end
            3'd1: begin
                alu_res      = diff;
                alu_overflow = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
            end
            3'd2: alu_res = alu_a & alu_b;
            3'd3: alu_res = alu_a | alu_b;
            3'd5: alu_res = alu_a >> alu_b;
            3'd6: alu_res = {alu_b[15:0], 16'h0};
            3'd7: alu_res = {31'b0, diff[31]};
            default: alu_res = 32'h0;
        endcase
    end
    assign alu_zero = (alu_res == 32'h0);

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct, opcode;
        logic [4:0]  shamt;
        logic [31:0] rs, rt;
        logic [15:0] imm;
    } ins_t;

    typedef struct {
        logic [31:0] res;
        logic        zero, trap, ill;
    } exp_t;

    typedef struct {
        ins_t        i;
        logic [2:0]  eop;
        logic [31:0] ea, eb;
        logic        chk_b;
        exp_t        e;
    } vec_t;

    int   total = 0, bad = 0, retired = 0;
    exp_t q[$];
    vec_t vq[$];
    logic [5:0]  fset[8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h02};
    logic [5:0]  oset[5] = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F};
    logic [31:0] sp[4]   = '{32'h7FFFFFFF, 32'h80000000, 32'h0, 32'hFFFFFFFF};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    function automatic logic ovf(input logic [31:0] a, input logic [31:0] b, input logic sub);
        longint s;
        s = sub ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Architectural result of one instruction, straight from the instruction semantics.
    function automatic exp_t ref_exec(input ins_t i);
        exp_t        e;
        logic [31:0] sx, zx, d;
        sx = {{16{i.imm[15]}}, i.imm};
        zx = {16'h0, i.imm};
        e  = '{res: 32'h0, zero: 1'b0, trap: 1'b0, ill: 1'b0};
        case (i.op)
            2'd0: e.res = i.rs + sx;
            2'd1: e.res = i.rs - i.rt;
            2'd2: case (i.funct)
                6'h20: begin e.res = i.rs + i.rt; e.trap = ovf(i.rs, i.rt, 0); end
                6'h21: e.res = i.rs + i.rt;
                6'h22: begin e.res = i.rs - i.rt; e.trap = ovf(i.rs, i.rt, 1); end
                6'h23: e.res = i.rs - i.rt;
                6'h24: e.res = i.rs & i.rt;
                6'h25: e.res = i.rs | i.rt;
                6'h2A: begin d = i.rs - i.rt; e.res = {31'b0, d[31]}; end
                6'h02: e.res = i.rt >> i.shamt;
                default: e.ill = 1;
            endcase
            default: case (i.opcode)
                6'h08: begin e.res = i.rs + sx; e.trap = ovf(i.rs, sx, 0); end
                6'h0C: e.res = i.rs & zx;
                6'h0D: e.res = i.rs | zx;
                6'h0A: begin d = i.rs - sx; e.res = {31'b0, d[31]}; end
                6'h0F: e.res = {i.imm, 16'h0};
                default: e.ill = 1;
            endcase
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t i;
        i.op     = 2'($urandom_range(0, 3));
        i.funct  = ($urandom_range(0, 8) == 8) ? 6'($urandom) : fset[$urandom_range(0, 7)];
        i.opcode = ($urandom_range(0, 5) == 5) ? 6'($urandom) : oset[$urandom_range(0, 4)];
        i.shamt  = 5'($urandom);
        i.rs     = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
        i.rt     = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
        i.imm    = 16'($urandom);
        return i;
    endfunction

    function automatic ins_t mk(input logic [1:0] op, input logic [5:0] f, input logic [5:0] o,
                                input logic [31:0] rs, input logic [31:0] rt);
        return '{op: op, funct: f, opcode: o, shamt: 5'd0, rs: rs, rt: rt, imm: 16'h0};
    endfunction

    task automatic add_vec(input logic [1:0] op, input logic [5:0] f, input logic [5:0] o,
                           input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                           input logic [15:0] im, input logic [2:0] eop, input logic [31:0] ea,
                           input logic [31:0] eb, input logic cb, input logic [31:0] er,
                           input logic ez, input logic et, input logic ei);
        vec_t v;
        v.i     = '{op: op, funct: f, opcode: o, shamt: sh, rs: rs, rt: rt, imm: im};
        v.eop   = eop;
        v.ea    = ea;
        v.eb    = eb;
        v.chk_b = cb;
        v.e     = '{res: er, zero: ez, trap: et, ill: ei};
        vq.push_back(v);
    endtask

    task automatic drive(input ins_t i);
        alu_op  = i.op;
        funct   = i.funct;
        opcode  = i.opcode;
        shamt   = i.shamt;
        rs_data = i.rs;
        rt_data = i.rt;
        imm     = i.imm;
    endtask

    // One cycle: drive at negedge, then check W against the model queue and record any acceptance.
    task automatic step(input logic iv, input ins_t i, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        flush     = fl;
        out_ready = ordy;
        drive(i);
        #1;
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'h0);
            else begin
                chk("q_res", out_res, q[0].res);
                chk("q_zero", {31'b0, out_zero}, {31'b0, q[0].zero});
                chk("q_trap", {31'b0, out_ovf_trap}, {31'b0, q[0].trap});
                chk("q_ill", {31'b0, out_illegal}, {31'b0, q[0].ill});
                if (out_ready) begin
                    void'(q.pop_front());
                    retired++;
                end
            end
        end
        if (in_valid && in_ready) q.push_back(ref_exec(i));
    endtask

    initial begin
        ins_t s[4];
        ins_t nop;
        int   idx, r0;
        nop = mk(2'd0, 6'h0, 6'h0, 32'h0, 32'h0);

        add_vec(2, 6'h20, 0, 0, 32'd5, 32'd7, 0, 3'd0, 32'd5, 32'd7, 1, 32'd12, 0, 0, 0);
        add_vec(2, 6'h20, 0, 0, 32'h7FFFFFFF, 1, 0, 3'd0, 32'h7FFFFFFF, 1, 1, 32'h80000000, 0, 1, 0);
        add_vec(2, 6'h21, 0, 0, 32'h7FFFFFFF, 1, 0, 3'd0, 32'h7FFFFFFF, 1, 1, 32'h80000000, 0, 0, 0);
        add_vec(3, 0, 6'h0F, 0, 32'hBEEF, 0, 16'h1234, 3'd6, 32'hBEEF, 32'h1234, 1, 32'h12340000, 0, 0, 0);
        add_vec(3, 0, 6'h0A, 0, 32'hFFFFFFFD, 0, 16'hFFFF, 3'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 1, 32'd1, 0, 0, 0);
        add_vec(2, 6'h02, 0, 5'd4, 32'h12345678, 32'h80000000, 0, 3'd5, 32'h80000000, 32'd4, 1, 32'h08000000, 0, 0, 0);
        add_vec(2, 6'h27, 0, 0, 32'hAAAA5555, 32'hFFFF, 0, 3'd4, 32'hAAAA5555, 32'hFFFF, 1, 32'h0, 1, 0, 1);
        add_vec(0, 0, 6'h23, 0, 32'd100, 0, 16'hFFFC, 3'd0, 32'd100, 32'hFFFFFFFC, 1, 32'd96, 0, 0, 0);
        add_vec(1, 0, 6'h04, 0, 32'd9, 32'd9, 0, 3'd1, 32'd9, 32'd9, 1, 32'h0, 1, 0, 0);
        add_vec(2, 6'h22, 0, 0, 32'h80000000, 1, 0, 3'd1, 32'h80000000, 1, 1, 32'h7FFFFFFF, 0, 1, 0);
        add_vec(2, 6'h23, 0, 0, 32'h80000000, 1, 0, 3'd1, 32'h80000000, 1, 1, 32'h7FFFFFFF, 0, 0, 0);
        add_vec(3, 0, 6'h0C, 0, 32'hFFFF00FF, 0, 16'hF0F0, 3'd2, 32'hFFFF00FF, 32'hF0F0, 1, 32'hF0, 0, 0, 0);
        add_vec(3, 0, 6'h0D, 0, 32'h12340000, 0, 16'h8001, 3'd3, 32'h12340000, 32'h8001, 1, 32'h12348001, 0, 0, 0);
        add_vec(3, 0, 6'h23, 0, 32'h55, 32'h66, 16'h7, 3'd4, 32'h55, 0, 0, 32'h0, 1, 0, 1);
        add_vec(2, 6'h2A, 0, 0, 32'd3, 32'd5, 0, 3'd7, 32'd3, 32'd5, 1, 32'd1, 0, 0, 0);
        add_vec(2, 6'h24, 0, 0, 32'hF0F0, 32'hFF00, 0, 3'd2, 32'hF0F0, 32'hFF00, 1, 32'hF000, 0, 0, 0);
        add_vec(3, 0, 6'h08, 0, 32'h7FFFFFFF, 0, 16'h1, 3'd0, 32'h7FFFFFFF, 32'd1, 1, 32'h80000000, 0, 1, 0);
        add_vec(3, 0, 6'h08, 0, 32'h10, 0, 16'hFFFF, 3'd0, 32'h10, 32'hFFFFFFFF, 1, 32'hF, 0, 0, 0);

        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_op", {29'b0, alu_operation}, 32'h0);
        chk("rst_a", alu_a, 32'h0);
        chk("rst_b", alu_b, 32'h0);
        chk("rst_res", out_res, 32'h0);
        chk("rst_flags", {29'b0, out_zero, out_ovf_trap, out_illegal}, 32'h0);

        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].i);
            in_valid  = 1;
            out_ready = 1;
            #1;
            chk($sformatf("v%0d_in_ready", k), {31'b0, in_ready}, 32'h1);
            @(negedge clk);
            in_valid = 0;
            #1;
            chk($sformatf("v%0d_op", k), {29'b0, alu_operation}, {29'b0, vq[k].eop});
            chk($sformatf("v%0d_a", k), alu_a, vq[k].ea);
            if (vq[k].chk_b) chk($sformatf("v%0d_b", k), alu_b, vq[k].eb);
            chk($sformatf("v%0d_early", k), {31'b0, out_valid}, 32'h0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_valid", k), {31'b0, out_valid}, 32'h1);
            chk($sformatf("v%0d_res", k), out_res, vq[k].e.res);
            chk($sformatf("v%0d_zero", k), {31'b0, out_zero}, {31'b0, vq[k].e.zero});
            chk($sformatf("v%0d_trap", k), {31'b0, out_ovf_trap}, {31'b0, vq[k].e.trap});
            chk($sformatf("v%0d_ill", k), {31'b0, out_illegal}, {31'b0, vq[k].e.ill});
        end

        // Back-to-back stream with a three-cycle consumer stall.
        q.delete();
        r0 = retired;
        for (int k = 0; k < 4; k++) s[k] = mk(2'd2, 6'h20, 6'h0, 32'(k + 1), 32'd100);
        step(1, s[0], 1, 0);
        step(1, s[1], 1, 0);
        step(1, s[2], 0, 0);
        chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
        step(1, s[2], 0, 0);
        chk("stall_in_ready2", {31'b0, in_ready}, 32'h0);
        step(1, s[2], 0, 0);
        idx = 2;
        for (int c = 0; c < 12; c++) begin
            step(idx < 4, s[idx < 4 ? idx : 3], 1, 0);
            if (in_valid && in_ready) idx++;
        end
        chk("stall_retired", 32'(retired - r0), 32'd4);
        chk("stall_q_empty", 32'(q.size()), 32'd0);

        // Flush with E=sub, W=or and the consumer stalled: or retires, sub vanishes.
        q.delete();
        r0 = retired;
        step(1, mk(2'd2, 6'h25, 6'h0, 32'hF0, 32'h0F), 1, 0);
        step(1, mk(2'd2, 6'h22, 6'h0, 32'h10, 32'h3), 1, 0);
        step(1, mk(2'd2, 6'h21, 6'h0, 32'h1, 32'h1), 0, 1);
        chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
        void'(q.pop_back());
        step(0, nop, 1, 0);
        chk("flush_or_retired", 32'(retired - r0), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step(0, nop, 1, 0);
            chk("flush_no_sub", {31'b0, out_valid}, 32'h0);
        end

        // Random stream against the model.
        q.delete();
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 3) != 0, rnd_ins(), $urandom_range(0, 3) != 0, 0);
        for (int c = 0; c < 10; c++) step(0, nop, 1, 0);
        chk("rand_drain", 32'(q.size()), 32'd0);

        // Reset mid-stream drops both entries.
        q.delete();
        step(1, mk(2'd2, 6'h20, 6'h0, 32'd1, 32'd2), 1, 0);
        step(1, mk(2'd2, 6'h21, 6'h0, 32'd3, 32'd4), 0, 0);
        @(negedge clk);
        rst      = 1;
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("mid_rst_op", {29'b0, alu_operation}, 32'h0);
        chk("mid_rst_a", alu_a, 32'h0);
        chk("mid_rst_res", out_res, 32'h0);
        q.delete();
        step(0, nop, 1, 0);
        chk("mid_rst_stays_empty", {31'b0, out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
